// File: rtl/sqrt_fp_unit.sv
// sqrt_fp_unit: iterative sqrt / inverse-sqrt coprocessor for an 8-bit
// mantissa, 8-bit signed exponent format. Inverse sqrt first forms
// floor(2^21 / (m*k)) with a bit-serial restoring divider, then both ops
// share one bit-serial non-restoring integer square root.
module sqrt_fp_unit (
  input  logic              clk,
  input  logic              rst,
  input  logic              DoSqrt_i,
  input  logic              DoInvSqrt_i,
  input  logic              s_i,
  input  logic [7:0]        m_i,
  input  logic signed [7:0] e_i,
  output logic              s_o,
  output logic [7:0]        m_o,
  output logic signed [7:0] e_o,
  output logic              valid_o
);

  typedef enum logic [1:0] {IDLE, DIV, SQRT, DONE} state_t;

  state_t state, state_nxt;

  // Latched operand and op type
  logic              inv_q;
  logic              sgn_q;
  logic [7:0]        man_q;
  logic signed [7:0] exp_q;
  logic [4:0]        cnt;

  // Restoring divider state
  logic [8:0]  dvs_q;
  logic [9:0]  rem_q;
  logic [15:0] quo_q;
  logic        ovf_q;

  // Non-restoring isqrt state
  logic [15:0]        rad_q;
  logic signed [13:0] r_q;
  logic [7:0]         q_q;

  // Quotient overflow (divisor <= 32, including zero) saturates to all ones;
  // the zero-divisor case lands on 0xFFFF through the same rule.
  function automatic logic [15:0] sat_quot(input logic ovf, input logic [15:0] quo);
    return ovf ? 16'hFFFF : quo;
  endfunction

  logic       start, accept, go_inv;
  logic [8:0] dvs_in;

  assign start  = DoSqrt_i | DoInvSqrt_i;
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign go_inv = DoInvSqrt_i & ~DoSqrt_i;
  // m*k with k = 2 for odd exponents
  assign dvs_in = e_i[0] ? {m_i, 1'b0} : {1'b0, m_i};

  // Divider step: shift in a zero, subtract when the divisor fits
  logic [9:0]  rem_sh, rem_nx;
  logic        div_ge;
  logic [15:0] quo_nx;

  assign rem_sh = rem_q << 1;
  assign div_ge = (rem_sh >= {1'b0, dvs_q});
  assign rem_nx = div_ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
  assign quo_nx = {quo_q[14:0], div_ge};

  // isqrt step: bring down two radicand bits, add or subtract the trial
  // term depending on the sign of the running remainder
  logic signed [13:0] r_sh, r_nx;
  logic [7:0]         q_nx;

  assign r_sh = (r_q <<< 2) + $signed({12'd0, rad_q[15:14]});
  assign r_nx = r_q[13] ? (r_sh + $signed({4'd0, q_q, 2'b11}))
                        : (r_sh - $signed({4'd0, q_q, 2'b01}));
  assign q_nx = {q_q[6:0], ~r_nx[13]};

  // Exponent halving and sqrt radicand P = m*128*k
  logic signed [7:0] half_e, neg_half_e;
  logic [15:0]       sqrt_rad;

  assign half_e     = exp_q >>> 1;
  assign neg_half_e = -half_e;
  assign sqrt_rad   = exp_q[0] ? {man_q, 8'd0} : {1'b0, man_q, 7'd0};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: DIV runs 16 steps, SQRT runs a load cycle plus 8 steps
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = go_inv ? DIV : SQRT;
      DIV:        if (cnt == 5'd15) state_nxt = SQRT;
      SQRT:       if (cnt == 5'd8) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Operand capture, divider and isqrt iterations, result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_q   <= 1'b0;
      sgn_q   <= 1'b0;
      man_q   <= '0;
      exp_q   <= '0;
      cnt     <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      ovf_q   <= 1'b0;
      rad_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      s_o     <= 1'b0;
      m_o     <= '0;
      e_o     <= '0;
      valid_o <= 1'b0;
    end else if (accept) begin
      inv_q   <= go_inv;
      sgn_q   <= s_i;
      man_q   <= m_i;
      exp_q   <= e_i;
      cnt     <= '0;
      // dividend 2^21 = 32 * 2^16: start the partial remainder at 32
      dvs_q   <= dvs_in;
      rem_q   <= 10'd32;
      quo_q   <= '0;
      ovf_q   <= (dvs_in <= 9'd32);
      valid_o <= 1'b0;
    end else begin
      case (state)
        DIV: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= (cnt == 5'd15) ? 5'd0 : cnt + 5'd1;
        end
        SQRT: begin
          if (cnt == 5'd0) begin
            rad_q <= inv_q ? sat_quot(ovf_q, quo_q) : sqrt_rad;
            r_q   <= '0;
            q_q   <= '0;
            cnt   <= 5'd1;
          end else begin
            rad_q <= rad_q << 2;
            r_q   <= r_nx;
            q_q   <= q_nx;
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd8) begin
              cnt     <= '0;
              m_o     <= q_nx;
              e_o     <= inv_q ? neg_half_e : half_e;
              s_o     <= sgn_q;
              valid_o <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_fp_unit.sv
// Directed and swept bench for sqrt_fp_unit with a scoreboard of expected
// results computed by an independent integer model.
module tb_sqrt_fp_unit;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              DoSqrt_i = 1'b0;
  logic              DoInvSqrt_i = 1'b0;
  logic              s_i = 1'b0;
  logic [7:0]        m_i = 8'd0;
  logic signed [7:0] e_i = 8'sd0;
  logic              s_o;
  logic [7:0]        m_o;
  logic signed [7:0] e_o;
  logic              valid_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] m;
    logic [7:0] e;
    logic       s;
    int         lat;
  } exp_t;

  exp_t sb[$];

  sqrt_fp_unit dut (
    .clk(clk), .rst(rst), .DoSqrt_i(DoSqrt_i), .DoInvSqrt_i(DoInvSqrt_i),
    .s_i(s_i), .m_i(m_i), .e_i(e_i),
    .s_o(s_o), .m_o(m_o), .e_o(e_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  function automatic int isqrt_ref(int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic exp_t model(bit inv, bit s, logic [7:0] m, logic signed [7:0] e);
    exp_t x;
    int ei, k, h, mi, rad;
    ei = e;
    mi = m;
    k  = (ei % 2 != 0) ? 2 : 1;
    h  = (ei - (k - 1)) / 2;
    if (!inv) rad = mi * 128 * k;
    else if (mi == 0) rad = 65535;
    else begin
      rad = 2097152 / (mi * k);
      if (rad > 65535) rad = 65535;
    end
    x.m   = 8'(isqrt_ref(rad));
    x.e   = 8'(inv ? -h : h);
    x.s   = s;
    x.lat = inv ? 25 : 9;
    return x;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One operation: strobe, check valid drops, wait bounded, score result.
  // poke drives both strobes mid-operation, which must be ignored.
  task automatic do_op(bit inv, bit both, bit s, logic [7:0] m, logic signed [7:0] e, bit poke);
    exp_t x;
    int   n;
    @(negedge clk);
    DoSqrt_i    = !inv || both;
    DoInvSqrt_i = inv || both;
    s_i = s;
    m_i = m;
    e_i = e;
    sb.push_back(model(inv && !both, s, m, e));
    @(posedge clk); #1;
    DoSqrt_i    = 1'b0;
    DoInvSqrt_i = 1'b0;
    m_i = 8'($urandom);
    e_i = 8'($urandom);
    s_i = ~s;
    chk("valid_low_after_start", {31'd0, valid_o}, 32'd0);
    n = 0;
    while (valid_o !== 1'b1 && n < 40) begin
      if (poke && n == 3) begin
        DoSqrt_i    = 1'b1;
        DoInvSqrt_i = 1'b1;
      end
      @(posedge clk); #1;
      n++;
      DoSqrt_i    = 1'b0;
      DoInvSqrt_i = 1'b0;
    end
    x = sb.pop_front();
    chk("latency", n, x.lat);
    chk("m_o", {24'd0, m_o}, {24'd0, x.m});
    chk("e_o", {24'd0, e_o}, {24'd0, x.e});
    chk("s_o", {31'd0, s_o}, {31'd0, x.s});
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_m", {24'd0, m_o}, 32'd0);
    chk("rst_e", {24'd0, e_o}, 32'd0);
    chk("rst_s", {31'd0, s_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // directed sqrt
    do_op(1'b0, 1'b0, 1'b0, 8'd128, 8'sd4, 1'b0);
    do_op(1'b0, 1'b0, 1'b0, 8'd128, 8'sd5, 1'b0);
    do_op(1'b0, 1'b0, 1'b0, 8'd64,  8'sd0, 1'b0);
    do_op(1'b0, 1'b0, 1'b1, 8'd200, 8'sd7, 1'b0);

    // directed inverse sqrt
    do_op(1'b1, 1'b0, 1'b0, 8'd128, 8'sd4,  1'b0);
    do_op(1'b1, 1'b0, 1'b0, 8'd64,  8'sd0,  1'b0);
    do_op(1'b1, 1'b0, 1'b1, 8'd128, -8'sd3, 1'b0);

    // out-of-range mantissa
    do_op(1'b0, 1'b0, 1'b0, 8'd0, 8'sd2, 1'b0);
    do_op(1'b1, 1'b0, 1'b0, 8'd0, 8'sd2, 1'b0);

    // edge exponents
    do_op(1'b0, 1'b0, 1'b0, 8'd150, -8'sd128, 1'b0);
    do_op(1'b1, 1'b0, 1'b0, 8'd150, -8'sd128, 1'b0);
    do_op(1'b0, 1'b0, 1'b0, 8'd255, 8'sd127,  1'b0);
    do_op(1'b1, 1'b0, 1'b0, 8'd255, 8'sd127,  1'b0);

    // both strobes -> sqrt; strobes while busy ignored
    do_op(1'b1, 1'b1, 1'b0, 8'd100, 8'sd3, 1'b0);
    do_op(1'b0, 1'b0, 1'b0, 8'd77,  8'sd9, 1'b1);
    do_op(1'b1, 1'b0, 1'b1, 8'd77,  -8'sd9, 1'b1);

    // reset mid-DIV aborts and clears outputs
    @(negedge clk);
    DoInvSqrt_i = 1'b1;
    m_i = 8'd128;
    e_i = 8'sd4;
    s_i = 1'b1;
    @(posedge clk); #1;
    DoInvSqrt_i = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, valid_o}, 32'd0);
    chk("midrst_m", {24'd0, m_o}, 32'd0);
    chk("midrst_e", {24'd0, e_o}, 32'd0);
    chk("midrst_s", {31'd0, s_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b1, 1'b0, 1'b0, 8'd128, 8'sd4, 1'b0);
    do_op(1'b0, 1'b0, 1'b1, 8'd128, 8'sd4, 1'b0);

    // sweep of normalized mantissas, both ops, random exponents
    for (int m = 64; m <= 254; m++) begin
      do_op(1'b0, 1'b0, 1'($urandom), 8'(m), 8'($urandom), 1'b0);
      do_op(1'b1, 1'b0, 1'($urandom), 8'(m), 8'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
